// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the fetch PC sequencer.
package fetch_pc_ctrl_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [PC_W-1:0] EXC_VEC_DEF  = 32'hBFC0_0380;
  localparam logic [PC_W-1:0] PC_INC_DEF   = 32'd4;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HOLD_BR = 1'b1
  } fetch_state_e;

  function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bus: decode/exception redirect inputs and fetch-side outputs.
interface fetch_pc_ctrl_if;
  import fetch_pc_ctrl_pkg::*;

  logic            stall_f;
  logic            id_valid;
  logic            id_is_branch;
  logic            id_take;
  logic [PC_W-1:0] id_target;
  logic            exc_redirect;
  logic [PC_W-1:0] exc_target;
  logic            inst_sram_en;
  logic [PC_W-1:0] pc_f;
  logic            adel_f;
  logic            ds_d;
  logic            redirect_pending;

  modport master (
    output stall_f, id_valid, id_is_branch, id_take, id_target,
           exc_redirect, exc_target,
    input  inst_sram_en, pc_f, adel_f, ds_d, redirect_pending
  );

  modport slave (
    input  stall_f, id_valid, id_is_branch, id_take, id_target,
           exc_redirect, exc_target,
    output inst_sram_en, pc_f, adel_f, ds_d, redirect_pending
  );

endinterface

// File: rtl/fetch_pc_ctrl_next_pc_mux.sv
// Priority mux for the next fetch PC: exception > held target > live branch > hold/increment.
module fetch_pc_ctrl_next_pc_mux
  import fetch_pc_ctrl_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] pc_inc_i,
  input  logic            stall_i,
  input  logic            exc_redirect_i,
  input  logic [PC_W-1:0] exc_target_i,
  input  logic            hold_release_i,
  input  logic [PC_W-1:0] tgt_i,
  input  logic            br_take_i,
  input  logic [PC_W-1:0] id_target_i,
  output logic [PC_W-1:0] next_pc_o
);

  always_comb begin
    next_pc_o = PC_W'(pc_i + pc_inc_i);
    if (exc_redirect_i) begin
      next_pc_o = exc_target_i;
    end else if (hold_release_i) begin
      next_pc_o = tgt_i;
    end else if (br_take_i) begin
      next_pc_o = id_target_i;
    end else if (stall_i) begin
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: owns the fetch PC, applies branch/exception redirects
// with delay-slot semantics and holds a taken branch across fetch stalls.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [PC_W-1:0] PC_INC   = PC_INC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_ctrl_if.slave  bus
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] tgt_q;
  logic            ds_q;
  logic            en_q;

  logic live_take;
  logic hold_release;
  logic br_take;

  assign live_take    = bus.id_valid & bus.id_is_branch & bus.id_take;
  assign hold_release = (state_q == ST_HOLD_BR) & ~bus.stall_f;
  assign br_take      = (state_q == ST_RUN) & live_take & ~bus.stall_f;

  fetch_pc_ctrl_next_pc_mux u_next_pc_mux (
    .pc_i           (pc_q),
    .pc_inc_i       (PC_INC),
    .stall_i        (bus.stall_f),
    .exc_redirect_i (bus.exc_redirect),
    .exc_target_i   (bus.exc_target),
    .hold_release_i (hold_release),
    .tgt_i          (tgt_q),
    .br_take_i      (br_take),
    .id_target_i    (bus.id_target),
    .next_pc_o      (pc_d)
  );

  // The first edge after reset only enables the SRAM so RESET_PC is actually fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      ds_q    <= 1'b0;
      en_q    <= 1'b0;
    end else if (!en_q) begin
      en_q <= 1'b1;
    end else begin
      pc_q <= pc_d;
      if (bus.exc_redirect) begin
        state_q <= ST_RUN;
        tgt_q   <= '0;
        ds_q    <= 1'b0;
      end else begin
        if (!bus.stall_f) begin
          ds_q <= bus.id_valid & bus.id_is_branch;
        end
        unique case (state_q)
          ST_RUN: begin
            if (live_take && bus.stall_f) begin
              tgt_q   <= bus.id_target;
              state_q <= ST_HOLD_BR;
            end
          end
          ST_HOLD_BR: begin
            if (!bus.stall_f) begin
              state_q <= ST_RUN;
            end
          end
          default: state_q <= ST_RUN;
        endcase
      end
    end
  end

  assign bus.inst_sram_en     = en_q;
  assign bus.pc_f             = pc_q;
  assign bus.adel_f           = pc_misaligned(pc_q);
  assign bus.ds_d             = ds_q;
  assign bus.redirect_pending = (state_q == ST_HOLD_BR);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Randomized and directed bench for fetch_pc_ctrl against a behavioural fetch model.
module tb_fetch_pc_ctrl;

  logic clk;
  logic rst;

  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic        m_pending;
  logic        m_ds;
  logic        m_en;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Next-cycle fetch state from the architectural rules, evaluated on the inputs at the edge.
  task automatic model_step();
    logic live;
    live = bus.id_valid & bus.id_is_branch & bus.id_take;
    if (rst) begin
      m_pc = 32'hBFC0_0000; m_en = 1'b0; m_ds = 1'b0; m_pending = 1'b0;
    end else if (!m_en) begin
      m_en = 1'b1;
    end else if (bus.exc_redirect) begin
      m_pc = bus.exc_target; m_pending = 1'b0; m_ds = 1'b0;
    end else if (bus.stall_f) begin
      if (!m_pending && live) begin
        m_pending = 1'b1;
        m_tgt = bus.id_target;
      end
    end else begin
      m_ds = bus.id_valid & bus.id_is_branch;
      if (m_pending) begin
        m_pc = m_tgt;
        m_pending = 1'b0;
      end else if (live) begin
        m_pc = bus.id_target;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_model();
    chk("pc_f", bus.pc_f, m_pc);
    chk("inst_sram_en", 32'(bus.inst_sram_en), 32'(m_en));
    chk("ds_d", 32'(bus.ds_d), 32'(m_ds));
    chk("redirect_pending", 32'(bus.redirect_pending), 32'(m_pending));
    chk("adel_f", 32'(bus.adel_f), 32'(m_pc[1:0] != 2'b00));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    bus.stall_f = 1'b0; bus.id_valid = 1'b0; bus.id_is_branch = 1'b0;
    bus.id_take = 1'b0; bus.id_target = '0; bus.exc_redirect = 1'b0;
    bus.exc_target = '0;
  endtask

  task automatic set_branch(input logic take, input logic [31:0] tgt);
    bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_take = take; bus.id_target = tgt;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_pc = 32'hBFC0_0000; m_tgt = '0; m_pending = 1'b0; m_ds = 1'b0; m_en = 1'b0;
    rst = 1'b1;
    idle_inputs();

    // Reset then free-run
    cycle();
    chk("lit_rst_en", 32'(bus.inst_sram_en), 32'd0);
    cycle();
    chk("lit_rst_pc", bus.pc_f, 32'hBFC0_0000);
    rst = 1'b0;
    cycle();
    chk("lit_run0", bus.pc_f, 32'hBFC0_0000);
    chk("lit_en1", 32'(bus.inst_sram_en), 32'd1);
    cycle();
    chk("lit_run1", bus.pc_f, 32'hBFC0_0004);
    cycle();
    chk("lit_run2", bus.pc_f, 32'hBFC0_0008);

    // Taken branch, no stall
    set_branch(1'b1, 32'hBFC0_0100);
    cycle();
    chk("lit_br_pc", bus.pc_f, 32'hBFC0_0100);
    chk("lit_br_ds", 32'(bus.ds_d), 32'd1);
    idle_inputs();
    cycle();
    chk("lit_after_br", bus.pc_f, 32'hBFC0_0104);

    // Taken branch under a 3-cycle stall; later id_target changes must be ignored
    set_branch(1'b1, 32'hBFC0_0100);
    bus.stall_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("lit_hold_pend", 32'(bus.redirect_pending), 32'd1);
      chk("lit_hold_pc", bus.pc_f, 32'hBFC0_0104);
      bus.id_target = 32'hDEAD_0000;
    end
    bus.stall_f = 1'b0;
    cycle();
    chk("lit_release_pc", bus.pc_f, 32'hBFC0_0100);
    chk("lit_release_pend", 32'(bus.redirect_pending), 32'd0);

    // Exception beats pending branch
    set_branch(1'b1, 32'hBFC0_0200);
    bus.stall_f = 1'b1;
    cycle();
    chk("lit_exc_pre_pend", 32'(bus.redirect_pending), 32'd1);
    bus.exc_redirect = 1'b1;
    bus.exc_target = 32'hBFC0_0380;
    cycle();
    chk("lit_exc_pc", bus.pc_f, 32'hBFC0_0380);
    chk("lit_exc_pend", 32'(bus.redirect_pending), 32'd0);
    chk("lit_exc_ds", 32'(bus.ds_d), 32'd0);
    idle_inputs();
    cycle();
    chk("lit_exc_next", bus.pc_f, 32'hBFC0_0384);

    // Not-taken branch then misaligned jump
    set_branch(1'b0, 32'hBFC0_0500);
    cycle();
    chk("lit_nt_pc", bus.pc_f, 32'hBFC0_0388);
    chk("lit_nt_ds", 32'(bus.ds_d), 32'd1);
    set_branch(1'b1, 32'h0040_0002);
    cycle();
    chk("lit_mis_pc", bus.pc_f, 32'h0040_0002);
    chk("lit_mis_adel", 32'(bus.adel_f), 32'd1);

    // Wrap
    idle_inputs();
    bus.exc_redirect = 1'b1;
    bus.exc_target = 32'hFFFF_FFFC;
    cycle();
    idle_inputs();
    cycle();
    chk("lit_wrap", bus.pc_f, 32'h0000_0000);

    // Reset during HOLD_BR
    set_branch(1'b1, 32'hBFC0_0700);
    bus.stall_f = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    chk("lit_rst_hold_pc", bus.pc_f, 32'hBFC0_0000);
    chk("lit_rst_hold_pend", 32'(bus.redirect_pending), 32'd0);
    rst = 1'b0;
    idle_inputs();
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst              = ($urandom_range(0, 199) == 0);
      bus.stall_f      = ($urandom_range(0, 2) == 0);
      bus.id_valid     = ($urandom_range(0, 3) != 0);
      bus.id_is_branch = ($urandom_range(0, 2) == 0);
      bus.id_take      = $urandom_range(0, 1) == 1;
      bus.id_target    = $urandom;
      if ($urandom_range(0, 7) != 0) bus.id_target[1:0] = 2'b00;
      bus.exc_redirect = ($urandom_range(0, 24) == 0);
      bus.exc_target   = ($urandom_range(0, 1) == 1) ? 32'hBFC0_0380 : 32'hFFFF_FFFC;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
